bru_resolve: RTL and testbench

- Branch-resolution unit: the execute-side counterpart of the static front-end predictor.
- Records every fetch-time prediction (jal/bxx, taken or not) in an in-order prediction queue.
- Pops the oldest entry when execute resolves a control instruction and compares actual next-PC against predicted next-PC.
- On mismatch: issues a registered PC redirect plus a one-cycle pipeline flush, holds the redirect until fetch acknowledges, and discards younger queue entries.

---
 rtl/bru_resolve.sv | 106 ++++++++++
 tb/tb_bru_resolve.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/bru_resolve.sv
// bru_resolve: branch-resolution unit with an in-order prediction queue, PC redirect and flush.
// Define BRU_RESOLVE_STAT_EN to add the stat_resolved / stat_mispred counters.
module bru_resolve #(
    parameter int PC_W = 64,
    parameter int DEPTH = 4,
    parameter logic [PC_W-1:0] START_PC = 'h8000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pred_valid,
    output logic                     pred_ready,
    input  logic [PC_W-1:0]          pred_pc,
    input  logic                     pred_taken,
    input  logic [PC_W-1:0]          pred_target,
    input  logic                     res_valid,
    input  logic [PC_W-1:0]          res_pc,
    input  logic                     res_taken,
    input  logic [PC_W-1:0]          res_target,
    output logic                     redirect,
    output logic [PC_W-1:0]          redirect_pc,
    input  logic                     redirect_ack,
    output logic                     flush,
    output logic                     order_err,
    output logic [$clog2(DEPTH):0]   q_count
`ifdef BRU_RESOLVE_STAT_EN
    ,
    output logic [31:0]              stat_resolved,
    output logic [31:0]              stat_mispred
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {RUN, REDIR} state_t;
    state_t state, state_nx;

    // Each slot keeps the predicted PC and the predicted next-PC already resolved at push time.
    logic [PC_W-1:0] q_pc [DEPTH];
    logic [PC_W-1:0] q_next [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic [PC_W-1:0] pred_next, act_next;
    logic push, pop, bad_order, mis, empty;

    always_comb begin
        empty      = count == '0;
        pred_next  = pred_taken ? pred_target : pred_pc + PC_W'(4);
        act_next   = res_taken ? res_target : res_pc + PC_W'(4);
        pred_ready = !rst && state == RUN && count < CW'(DEPTH);
        push       = pred_valid && pred_ready;
        pop        = res_valid && state == RUN;
        bad_order  = pop && (empty || res_pc != q_pc[rd_ptr]);
        mis        = pop && (bad_order || act_next != q_next[rd_ptr]);
        state_nx   = state == RUN ? (mis ? REDIR : RUN) : (redirect_ack ? RUN : REDIR);
        redirect   = state == REDIR;
        q_count    = count;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (push && !mis) begin
            q_pc[wr_ptr]   <= pred_pc;
            q_next[wr_ptr] <= pred_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            redirect_pc <= START_PC;
            flush       <= 1'b0;
            order_err   <= 1'b0;
        end else begin
            flush <= mis;
            if (bad_order) order_err <= 1'b1;
            if (mis) begin
                rd_ptr      <= '0;
                wr_ptr      <= '0;
                count       <= '0;
                redirect_pc <= act_next;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

`ifdef BRU_RESOLVE_STAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_resolved <= '0;
            stat_mispred  <= '0;
        end else begin
            if (pop && ~&stat_resolved) stat_resolved <= stat_resolved + 32'd1;
            if (mis && ~&stat_mispred)  stat_mispred  <= stat_mispred + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_bru_resolve.sv
// tb_bru_resolve: directed vector table plus randomized traffic against a queue-based reference model.
module tb_bru_resolve;
    localparam int DEPTH = 4;
    localparam logic [63:0] B = 64'h8000_0000;

    logic clk = 1'b0, rst = 1'b1;
    logic pred_valid = 1'b0, pred_taken = 1'b0, res_valid = 1'b0, res_taken = 1'b0, redirect_ack = 1'b0;
    logic [63:0] pred_pc = '0, pred_target = '0, res_pc = '0, res_target = '0;
    logic pred_ready, redirect, flush, order_err;
    logic [63:0] redirect_pc;
    logic [2:0] q_count;
`ifdef BRU_RESOLVE_STAT_EN
    logic [31:0] stat_resolved, stat_mispred;
`endif
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    bru_resolve dut (
        .clk(clk), .rst(rst),
        .pred_valid(pred_valid), .pred_ready(pred_ready), .pred_pc(pred_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .res_valid(res_valid), .res_pc(res_pc), .res_taken(res_taken), .res_target(res_target),
        .redirect(redirect), .redirect_pc(redirect_pc), .redirect_ack(redirect_ack),
        .flush(flush), .order_err(order_err), .q_count(q_count)
`ifdef BRU_RESOLVE_STAT_EN
        , .stat_resolved(stat_resolved), .stat_mispred(stat_mispred)
`endif
    );

    typedef struct {
        logic [63:0] pc;
        logic        taken;
        logic [63:0] target;
    } ent_t;
    ent_t mq[$];
    bit m_redir, m_flush, m_err;
    logic [63:0] m_rpc;
    int m_res, m_mis;

    typedef struct {
        logic pv; logic [63:0] ppc; logic pt; logic [63:0] ptgt;
        logic rv; logic [63:0] rpc; logic rt; logic [63:0] rtgt; logic ack;
        logic e_redir; logic e_flush; int e_cnt; logic [63:0] e_rpc; logic e_rdy; logic e_err;
    } vec_t;
    vec_t tv[21];

    task automatic model_reset();
        mq.delete();
        m_redir = 0; m_flush = 0; m_err = 0; m_rpc = B; m_res = 0; m_mis = 0;
    endtask

    task automatic model_step();
        logic [63:0] act, pnext;
        bit pop, push, bd, mis;
        ent_t e;
        if (m_redir) begin
            m_flush = 0;
            if (redirect_ack) m_redir = 0;
            return;
        end
        pop  = res_valid;
        push = pred_valid && mq.size() < DEPTH;
        act  = res_taken ? res_target : res_pc + 64'd4;
        bd   = pop && (mq.size() == 0 || mq[0].pc != res_pc);
        pnext = 0;
        if (mq.size() > 0) pnext = mq[0].taken ? mq[0].target : mq[0].pc + 64'd4;
        mis  = pop && (bd || act != pnext);
        m_flush = mis;
        if (bd) m_err = 1;
        if (pop) m_res++;
        if (mis) m_mis++;
        if (mis) begin
            mq.delete();
            m_redir = 1;
            m_rpc = act;
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) begin
                e.pc = pred_pc; e.taken = pred_taken; e.target = pred_target;
                mq.push_back(e);
            end
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, a, e);
        end
    endtask

    task automatic chk_model();
        chk("redirect", 64'(redirect), 64'(m_redir));
        chk("redirect_pc", redirect_pc, m_rpc);
        chk("flush", 64'(flush), 64'(m_flush));
        chk("order_err", 64'(order_err), 64'(m_err));
        chk("q_count", 64'(q_count), 64'(mq.size()));
        chk("pred_ready", 64'(pred_ready), 64'(!m_redir && mq.size() < DEPTH));
`ifdef BRU_RESOLVE_STAT_EN
        chk("stat_resolved", 64'(stat_resolved), 64'(m_res));
        chk("stat_mispred", 64'(stat_mispred), 64'(m_mis));
`endif
    endtask

    task automatic drive(input logic pv, input logic [63:0] ppc, input logic pt, input logic [63:0] ptgt,
                         input logic rv, input logic [63:0] rpc, input logic rt, input logic [63:0] rtgt,
                         input logic ack);
        pred_valid = pv; pred_pc = ppc; pred_taken = pt; pred_target = ptgt;
        res_valid = rv; res_pc = rpc; res_taken = rt; res_target = rtgt; redirect_ack = ack;
        model_step();
        @(posedge clk);
        #1;
        chk_model();
    endtask

    initial begin
        tv[0]  = '{1, B, 1, B+'h10,        0, 0, 0, 0,            0, 0, 0, 1, B, 1, 0};
        tv[1]  = '{0, 0, 0, 0,             1, B, 1, B+'h10,       0, 0, 0, 0, B, 1, 0};
        tv[2]  = '{1, B+'h20, 1, B+'h40,   0, 0, 0, 0,            0, 0, 0, 1, B, 1, 0};
        tv[3]  = '{0, 0, 0, 0,             1, B+'h20, 0, 0,       0, 1, 1, 0, B+'h24, 0, 0};
        tv[4]  = '{0, 0, 0, 0,             0, 0, 0, 0,            0, 1, 0, 0, B+'h24, 0, 0};
        tv[5]  = '{0, 0, 0, 0,             0, 0, 0, 0,            0, 1, 0, 0, B+'h24, 0, 0};
        tv[6]  = '{0, 0, 0, 0,             0, 0, 0, 0,            1, 0, 0, 0, B+'h24, 1, 0};
        tv[7]  = '{1, B+'h100, 0, 0,       0, 0, 0, 0,            0, 0, 0, 1, B+'h24, 1, 0};
        tv[8]  = '{1, B+'h104, 0, 0,       0, 0, 0, 0,            0, 0, 0, 2, B+'h24, 1, 0};
        tv[9]  = '{1, B+'h108, 0, 0,       0, 0, 0, 0,            0, 0, 0, 3, B+'h24, 1, 0};
        tv[10] = '{1, B+'h10c, 0, 0,       0, 0, 0, 0,            0, 0, 0, 4, B+'h24, 0, 0};
        tv[11] = '{1, B+'h110, 0, 0,       0, 0, 0, 0,            0, 0, 0, 4, B+'h24, 0, 0};
        tv[12] = '{1, B+'h110, 0, 0,       1, B+'h100, 0, 0,      0, 0, 0, 3, B+'h24, 1, 0};
        tv[13] = '{0, 0, 0, 0,             1, B+'h104, 0, 0,      0, 0, 0, 2, B+'h24, 1, 0};
        tv[14] = '{0, 0, 0, 0,             1, B+'h108, 0, 0,      0, 0, 0, 1, B+'h24, 1, 0};
        tv[15] = '{0, 0, 0, 0,             1, B+'h10c, 0, 0,      0, 0, 0, 0, B+'h24, 1, 0};
        tv[16] = '{0, 0, 0, 0,             1, B+'h200, 0, 0,      0, 1, 1, 0, B+'h204, 0, 1};
        tv[17] = '{0, 0, 0, 0,             0, 0, 0, 0,            1, 0, 0, 0, B+'h204, 1, 1};
        tv[18] = '{1, B+'h300, 0, 0,       0, 0, 0, 0,            0, 0, 0, 1, B+'h204, 1, 1};
        tv[19] = '{0, 0, 0, 0,             1, B+'h400, 1, B+'h500, 0, 1, 1, 0, B+'h500, 0, 1};
        tv[20] = '{0, 0, 0, 0,             0, 0, 0, 0,            0, 1, 0, 0, B+'h500, 0, 1};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("ready_in_reset", 64'(pred_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_rpc_low", 64'(redirect_pc[31:0]), 64'h8000_0000);
        chk("reset_qcount", 64'(q_count), 64'd0);
        chk("reset_ready", 64'(pred_ready), 64'd1);
        chk_model();

        for (int i = 0; i < 21; i++) begin
            drive(tv[i].pv, tv[i].ppc, tv[i].pt, tv[i].ptgt, tv[i].rv, tv[i].rpc, tv[i].rt, tv[i].rtgt, tv[i].ack);
            chk($sformatf("v%0d_redirect", i), 64'(redirect), 64'(tv[i].e_redir));
            chk($sformatf("v%0d_flush", i), 64'(flush), 64'(tv[i].e_flush));
            chk($sformatf("v%0d_qcount", i), 64'(q_count), 64'(tv[i].e_cnt));
            chk($sformatf("v%0d_rpc", i), redirect_pc, tv[i].e_rpc);
            chk($sformatf("v%0d_ready", i), 64'(pred_ready), 64'(tv[i].e_rdy));
            chk($sformatf("v%0d_err", i), 64'(order_err), 64'(tv[i].e_err));
        end

        // Still redirecting here: the asynchronous reset must drop redirect without a clock edge.
        #2;
        rst = 1'b1;
        #1;
        chk("async_redirect", 64'(redirect), 64'd0);
        chk("async_qcount", 64'(q_count), 64'd0);
        chk("async_ready", 64'(pred_ready), 64'd0);
        chk("async_err", 64'(order_err), 64'd0);
`ifdef BRU_RESOLVE_STAT_EN
        chk("async_stat_res", 64'(stat_resolved), 64'd0);
        chk("async_stat_mis", 64'(stat_mispred), 64'd0);
`endif
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

        drive(1, B, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, B, 0, 0, 0);
        drive(1, B+'h8, 1, B+'h80, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, B+'h8, 1, B+'h80, 0);
        drive(1, B+'h10, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, B+'h10, 1, B+'h90, 0);
        chk("seq_rpc", redirect_pc, B+'h90);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("seq_released", 64'(redirect), 64'd0);
        chk("seq_err_clear", 64'(order_err), 64'd0);
`ifdef BRU_RESOLVE_STAT_EN
        chk("seq_stat_res", 64'(stat_resolved), 64'd3);
        chk("seq_stat_mis", 64'(stat_mispred), 64'd1);
`endif

        for (int n = 0; n < 600; n++) begin
            logic pv, pt, rv, rt, ack;
            logic [63:0] ppc, ptgt, rpc, rtgt;
            pv   = 1'($urandom_range(0, 1));
            ppc  = B + 64'(4 * $urandom_range(0, 7));
            pt   = 1'($urandom_range(0, 1));
            ptgt = B + 64'('h40 * $urandom_range(0, 3));
            rv   = $urandom_range(0, 9) < 4;
            rpc  = B + 64'(4 * $urandom_range(0, 7));
            rt   = 1'($urandom_range(0, 1));
            rtgt = B + 64'('h40 * $urandom_range(0, 3));
            if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
                rpc = mq[0].pc;
                if ($urandom_range(0, 2) != 0) begin
                    rt = mq[0].taken;
                    rtgt = mq[0].target;
                end
            end
            ack = $urandom_range(0, 2) == 0;
            drive(pv, ppc, pt, ptgt, rv, rpc, rt, rtgt, ack);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
